// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared definitions for the DRAM command-port arbiter.
//   - arb_state_t : arbiter FSM states
//   - OWN_*       : codes presented on the arbiter's owner output
//   - DEF_*       : default bus widths used as parameter defaults
package dram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 25;
  localparam int unsigned DEF_DATA_W = 256;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WR = 2'd1,
    GRANT_RD = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WR   = 2'd1;
  localparam logic [1:0] OWN_RD   = 2'd2;

endpackage

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM controller command port between a write
// client (RX-buffer address generator) and a read client (trigger readout).
// Ownership is granted per transaction of a fixed number of accepted beats.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_req/wr_len/wr_gnt     write client request, length (beats), grant
//   wr_enable/addr/data/...  write beat command; wr_accept = beat taken
//   rd_req/rd_len/rd_gnt     read client request, length (commands), grant
//   rd_enable/addr/...       read command; rd_accept = command taken
//   rd_data/rd_data_valid    read return, passed through from the controller
//   DRAM_*                   controller command port (DRAM_Wait_Request = 1
//                            means the controller accepts this cycle)
//   owner                    0 = none, 1 = write, 2 = read
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned LEN_W         = DEF_LEN_W,
  parameter int unsigned MAX_WR_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_gnt,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_burst_begin,
  input  logic [4:0]        wr_burst_count,
  output logic              wr_accept,
  input  logic              rd_req,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_gnt,
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_burst_begin,
  input  logic [4:0]        rd_burst_count,
  output logic              rd_accept,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              DRAM_Wait_Request,
  output logic              DRAM_Write_Enable,
  output logic              DRAM_Read_Enable,
  output logic              DRAM_Burst_Begin,
  output logic [4:0]        DRAM_Burst_Count,
  output logic [ADDR_W-1:0] DRAM_Addr,
  output logic [DATA_W-1:0] DRAM_Write_Data,
  input  logic [DATA_W-1:0] DRAM_Read_Data,
  input  logic              DRAM_Read_Data_Valid,
  output logic [1:0]        owner
);

  localparam int unsigned CW = $clog2(MAX_WR_CONSEC + 1);

  arb_state_t        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [CW-1:0]     r_wr_consec;

  logic w_wr_own;
  logic w_rd_own;
  logic w_pick_wr;
  logic w_pick_rd;
  logic w_last;

  assign w_wr_own = (r_state == GRANT_WR);
  assign w_rd_own = (r_state == GRANT_RD);

  // Write wins a tie unless it has already taken MAX_WR_CONSEC grants in a
  // row while a read was waiting.
  assign w_pick_wr = wr_req & (~rd_req | (r_wr_consec != CW'(MAX_WR_CONSEC)));
  assign w_pick_rd = rd_req & ~w_pick_wr;

  assign wr_gnt    = w_wr_own;
  assign rd_gnt    = w_rd_own;
  assign wr_accept = w_wr_own & wr_enable & DRAM_Wait_Request;
  assign rd_accept = w_rd_own & rd_enable & DRAM_Wait_Request;
  assign w_last    = (r_beat == (r_len - LEN_W'(1)));

  assign owner = w_wr_own ? OWN_WR : (w_rd_own ? OWN_RD : OWN_NONE);

  // Read returns are not gated by ownership: data for commands issued in an
  // earlier read transaction may arrive while the write client owns the port.
  assign rd_data       = DRAM_Read_Data;
  assign rd_data_valid = DRAM_Read_Data_Valid;

  always_comb begin
    DRAM_Write_Enable = 1'b0;
    DRAM_Read_Enable  = 1'b0;
    DRAM_Burst_Begin  = 1'b0;
    DRAM_Burst_Count  = '0;
    DRAM_Addr         = '0;
    DRAM_Write_Data   = '0;
    if (w_wr_own) begin
      DRAM_Write_Enable = wr_enable;
      DRAM_Burst_Begin  = wr_burst_begin;
      DRAM_Burst_Count  = wr_burst_count;
      DRAM_Addr         = wr_addr;
      DRAM_Write_Data   = wr_data;
    end else if (w_rd_own) begin
      DRAM_Read_Enable  = rd_enable;
      DRAM_Burst_Begin  = rd_burst_begin;
      DRAM_Burst_Count  = rd_burst_count;
      DRAM_Addr         = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_beat      <= '0;
      r_wr_consec <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_wr) begin
            r_state     <= GRANT_WR;
            r_len       <= (wr_len == '0) ? LEN_W'(1) : wr_len;
            r_beat      <= '0;
            // w_pick_wr with rd_req set implies the counter is below its
            // limit, so the increment cannot pass MAX_WR_CONSEC.
            r_wr_consec <= rd_req ? r_wr_consec + CW'(1) : '0;
          end else if (w_pick_rd) begin
            r_state     <= GRANT_RD;
            r_len       <= (rd_len == '0) ? LEN_W'(1) : rd_len;
            r_beat      <= '0;
            r_wr_consec <= '0;
          end
        end
        GRANT_WR: begin
          if (wr_accept) begin
            if (w_last) r_state <= IDLE;
            else        r_beat  <= r_beat + LEN_W'(1);
          end
        end
        GRANT_RD: begin
          if (rd_accept) begin
            if (w_last) r_state <= IDLE;
            else        r_beat  <= r_beat + LEN_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: self-checking bench for dram_port_arbiter.
// Beats presented by a client are queued as expected controller commands and
// popped when the matching accept is seen; read returns and grant order are
// checked through their own queues.
module tb_dram_port_arbiter;
  import dram_arb_pkg::*;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req, rd_req;
  logic [LEN_W-1:0]  wr_len, rd_len;
  logic              wr_gnt, rd_gnt;
  logic              wr_enable, rd_enable;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_burst_begin, rd_burst_begin;
  logic [4:0]        wr_burst_count, rd_burst_count;
  logic              wr_accept, rd_accept;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              DRAM_Wait_Request;
  logic              DRAM_Write_Enable, DRAM_Read_Enable;
  logic              DRAM_Burst_Begin;
  logic [4:0]        DRAM_Burst_Count;
  logic [ADDR_W-1:0] DRAM_Addr;
  logic [DATA_W-1:0] DRAM_Write_Data;
  logic [DATA_W-1:0] DRAM_Read_Data;
  logic              DRAM_Read_Data_Valid;
  logic [1:0]        owner;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [511:0]      beat_q[$];
  logic [DATA_W-1:0] rq[$];
  logic [1:0]        gq[$];

  dram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_WR_CONSEC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_burst_begin(wr_burst_begin), .wr_burst_count(wr_burst_count),
    .wr_accept(wr_accept),
    .rd_req(rd_req), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .rd_enable(rd_enable), .rd_addr(rd_addr),
    .rd_burst_begin(rd_burst_begin), .rd_burst_count(rd_burst_count),
    .rd_accept(rd_accept), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .DRAM_Wait_Request(DRAM_Wait_Request),
    .DRAM_Write_Enable(DRAM_Write_Enable), .DRAM_Read_Enable(DRAM_Read_Enable),
    .DRAM_Burst_Begin(DRAM_Burst_Begin), .DRAM_Burst_Count(DRAM_Burst_Count),
    .DRAM_Addr(DRAM_Addr), .DRAM_Write_Data(DRAM_Write_Data),
    .DRAM_Read_Data(DRAM_Read_Data), .DRAM_Read_Data_Valid(DRAM_Read_Data_Valid),
    .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Present a new beat for the owning client; the other client's command
  // fields get different values so a wrong mux selection shows up.
  task automatic present(input bit is_rd);
    logic [ADDR_W-1:0] a;
    logic [4:0]        bc;
    logic              bb;
    logic [DATA_W-1:0] d;
    a  = ADDR_W'($urandom);
    bc = 5'($urandom);
    bb = 1'($urandom);
    d  = rand_data();
    wr_data = d;
    if (is_rd) begin
      rd_addr = a; rd_burst_count = bc; rd_burst_begin = bb;
      wr_addr = ~a; wr_burst_count = ~bc; wr_burst_begin = ~bb;
      beat_q.push_back({bb, bc, a, {DATA_W{1'b0}}});
    end else begin
      wr_addr = a; wr_burst_count = bc; wr_burst_begin = bb;
      rd_addr = ~a; rd_burst_count = ~bc; rd_burst_begin = ~bb;
      beat_q.push_back({bb, bc, a, d});
    end
  endtask

  // One transaction from IDLE. The other client holds its enable high with
  // no request. stall gives Wait_Request for the first n_stall granted
  // cycles; ret_n read returns are pulsed during the grant; rst_at != 0
  // asserts reset after that many accepts.
  task automatic xfer(input bit is_rd, input int unsigned len,
                      input logic [15:0] stall, input int unsigned n_stall,
                      input int unsigned ret_n, input int unsigned rst_at);
    int unsigned need, acc, cyc, rets, seen;
    bit          fresh, rv;
    logic        gnt, accp;
    need = (len == 0) ? 1 : len;
    acc = 0; cyc = 0; rets = 0; seen = 0; fresh = 1'b0;
    beat_q.delete();
    rq.delete();
    wr_enable = 1'b1;
    rd_enable = 1'b1;
    if (is_rd) begin rd_req = 1'b1; rd_len = LEN_W'(len); end
    else       begin wr_req = 1'b1; wr_len = LEN_W'(len); end
    present(is_rd);
    DRAM_Wait_Request = 1'b1;
    #2;
    chk("gnt_idle", is_rd ? rd_gnt : wr_gnt, 1'b0);
    while (acc < need && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 1) begin wr_req = 1'b0; rd_req = 1'b0; end
      if (fresh) begin present(is_rd); fresh = 1'b0; end
      DRAM_Wait_Request = ((cyc - 1) < n_stall) ? stall[4'(cyc - 1)] : 1'b1;
      rv = (rets < ret_n) && cyc[0];
      DRAM_Read_Data_Valid = rv;
      DRAM_Read_Data = rand_data();
      if (rv) begin rq.push_back(DRAM_Read_Data); rets++; end
      #2;
      gnt  = is_rd ? rd_gnt : wr_gnt;
      accp = is_rd ? rd_accept : wr_accept;
      chk("gnt_held", gnt, 1'b1);
      chk("owner", owner, is_rd ? OWN_RD : OWN_WR);
      chk("accept", accp, DRAM_Wait_Request);
      chk("nonowner_accept", is_rd ? wr_accept : rd_accept, 1'b0);
      chk("own_strobe", is_rd ? DRAM_Read_Enable : DRAM_Write_Enable, 1'b1);
      chk("other_strobe", is_rd ? DRAM_Write_Enable : DRAM_Read_Enable, 1'b0);
      chk("rd_valid", rd_data_valid, rv);
      if (rd_data_valid) begin
        if (rq.size() == 0) chk("ret_underflow", 1'b1, 1'b0);
        else chk("rd_data", rd_data, rq.pop_front());
        seen++;
      end
      if (accp) begin
        if (beat_q.size() == 0) chk("beat_underflow", 1'b1, 1'b0);
        else chk("beat", {DRAM_Burst_Begin, DRAM_Burst_Count, DRAM_Addr, DRAM_Write_Data},
                 beat_q.pop_front());
        acc++;
        fresh = (acc < need);
        if (rst_at != 0 && acc == rst_at) begin
          tick();
          rst = 1'b1;
          DRAM_Read_Data_Valid = 1'b0;
          tick();
          #2;
          chk("rst_owner", owner, OWN_NONE);
          chk("rst_gnt", {wr_gnt, rd_gnt}, 2'b00);
          chk("rst_accept", {wr_accept, rd_accept}, 2'b00);
          chk("rst_cmd", {DRAM_Write_Enable, DRAM_Read_Enable, DRAM_Burst_Begin,
                          DRAM_Burst_Count, DRAM_Addr, DRAM_Write_Data}, '0);
          tick();
          rst = 1'b0;
          wr_enable = 1'b0;
          rd_enable = 1'b0;
          beat_q.delete();
          return;
        end
      end
    end
    chk("accepts", acc, need);
    chk("returns", seen, ret_n);
    tick();
    DRAM_Read_Data_Valid = 1'b0;
    #2;
    chk("release_gnt", {wr_gnt, rd_gnt}, 2'b00);
    chk("release_owner", owner, OWN_NONE);
    chk("release_accept", {wr_accept, rd_accept}, 2'b00);
    chk("release_strobe", {DRAM_Write_Enable, DRAM_Read_Enable}, 2'b00);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
  endtask

  initial begin
    int unsigned grants, cyc;
    logic [1:0]  prev;

    rst = 1'b1;
    wr_req = 0; rd_req = 0; wr_len = '0; rd_len = '0;
    wr_enable = 0; rd_enable = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_burst_begin = 0; rd_burst_begin = 0; wr_burst_count = '0; rd_burst_count = '0;
    DRAM_Wait_Request = 1'b1; DRAM_Read_Data = '0; DRAM_Read_Data_Valid = 1'b0;

    // Reset: client enables and requests active must not leak through.
    tick(); tick();
    wr_req = 1; rd_req = 1; wr_enable = 1; rd_enable = 1;
    wr_addr = 25'h1ABCDEF; wr_data = rand_data(); wr_burst_count = 5'h1F;
    tick();
    #2;
    chk("reset_owner", owner, OWN_NONE);
    chk("reset_gnt", {wr_gnt, rd_gnt}, 2'b00);
    chk("reset_cmd", {DRAM_Write_Enable, DRAM_Read_Enable, DRAM_Burst_Begin,
                      DRAM_Burst_Count, DRAM_Addr, DRAM_Write_Data}, '0);
    wr_req = 0; rd_req = 0; wr_enable = 0; rd_enable = 0;
    tick();
    rst = 1'b0;
    tick();

    // Long write with no stalls.
    xfer(1'b0, 124, 16'h0000, 0, 0, 0);

    // Stalled write: Wait_Request 1,0,0,1,1,0,1.
    xfer(1'b0, 4, 16'b0000_0000_0101_1001, 7, 0, 0);

    // Both requesters held: write gets four grants, then read gets one.
    gq = '{OWN_WR, OWN_WR, OWN_WR, OWN_WR, OWN_RD,
           OWN_WR, OWN_WR, OWN_WR, OWN_WR, OWN_RD};
    wr_req = 1; rd_req = 1; wr_len = 8'd2; rd_len = 8'd2;
    wr_enable = 1; rd_enable = 1; DRAM_Wait_Request = 1;
    prev = OWN_NONE; grants = 0; cyc = 0;
    while (grants < 10 && cyc < 200) begin
      tick();
      cyc++;
      #2;
      if (owner != prev && owner != OWN_NONE) begin
        chk("bubble", prev, OWN_NONE);
        chk("grant_order", owner, gq.pop_front());
        grants++;
      end
      prev = owner;
    end
    chk("grant_count", grants, 10);
    wr_req = 0; rd_req = 0;
    cyc = 0;
    while (owner != OWN_NONE && cyc < 20) begin tick(); cyc++; #2; end
    chk("arb_idle", owner, OWN_NONE);
    wr_enable = 0; rd_enable = 0;
    tick();

    // Read of 3, then a write during which the read data comes back.
    xfer(1'b1, 3, 16'h0000, 0, 0, 0);
    xfer(1'b0, 8, 16'h0000, 0, 3, 0);

    // Reset after 50 beats of a 124-beat write, then a fresh transaction.
    xfer(1'b0, 124, 16'h0000, 0, 0, 50);
    xfer(1'b0, 4, 16'h0000, 0, 0, 0);

    // Zero-length read behaves as a single command.
    xfer(1'b1, 0, 16'h0000, 0, 0, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
